layer2_window_fetch: RTL

Streams 3×3 convolution windows out of the layer-1 result memory for the layer-2 convolution engine. Started by a one-cycle pulse, it walks every valid layer-2 output position of the 30×30 layer-1 map (28×28 positions, stride 1, no padding). For each position it issues nine read addresses to `layer1_result_mem` and delivers the 128-bit words, in tap order, on a valid/ready stream with position and tap tags. A 2-entry skid buffer absorbs the memory's 1-cycle read latency, so downstream backpressure never drops data.

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/layer2_window_fetch_if.sv | 23 ++
 rtl/win_skid_buf.sv | 76 +++++++
 rtl/layer2_window_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Constants and types shared by the layer-2 window fetch path:
// map geometry, FSM state encoding and the per-word tag carried beside the pixel data.
package cnn_pkg;
   localparam int MAP_W  = 30;
   localparam int K      = 3;
   localparam int OUT_W  = MAP_W - K + 1;
   localparam int DATA_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } win_fetch_state_t;

   typedef struct packed {
      logic [3:0] tap;
      logic [7:0] row;
      logic [7:0] col;
      logic       last_tap;
      logic       last;
   } win_tag_t;

   // Row-major tap number inside the 3x3 kernel
   function automatic logic [3:0] tap_index(input logic [1:0] k_row, input logic [1:0] k_col);
      return ({2'b00, k_row} * 4'd3) + {2'b00, k_col};
   endfunction
endpackage

// File: rtl/layer2_window_fetch_if.sv
// Valid/ready window stream from the fetch block to the layer-2 convolution engine.
interface layer2_window_fetch_if #(
   parameter int DATA_W = 128
);
   logic              win_valid;
   logic              win_ready;
   logic [DATA_W-1:0] win_data;
   logic [3:0]        win_tap;
   logic [7:0]        win_row;
   logic [7:0]        win_col;
   logic              win_last_tap;
   logic              win_last;

   modport master (
      output win_valid, win_data, win_tap, win_row, win_col, win_last_tap, win_last,
      input  win_ready
   );

   modport slave (
      input  win_valid, win_data, win_tap, win_row, win_col, win_last_tap, win_last,
      output win_ready
   );
endinterface

// File: rtl/win_skid_buf.sv
// Two-entry FIFO holding captured memory words with their tags; entry 0 is always the
// head so the stream outputs come straight from registers.
module win_skid_buf
   import cnn_pkg::*;
#(
   parameter int DATA_W = cnn_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  win_tag_t          push_tag,
   input  logic              pop,
   output logic [1:0]        occupancy,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_data,
   output win_tag_t          head_tag
);
   logic              valid0_r;
   logic              valid1_r;
   logic [DATA_W-1:0] data0_r;
   logic [DATA_W-1:0] data1_r;
   win_tag_t          tag0_r;
   win_tag_t          tag1_r;

   // Shift-register FIFO: a pop moves entry 1 forward, a push fills the first free slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid0_r <= 1'b0;
         valid1_r <= 1'b0;
         data0_r  <= '0;
         data1_r  <= '0;
         tag0_r   <= '0;
         tag1_r   <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (!valid0_r) begin
                  data0_r  <= push_data;
                  tag0_r   <= push_tag;
                  valid0_r <= 1'b1;
               end else begin
                  data1_r  <= push_data;
                  tag1_r   <= push_tag;
                  valid1_r <= 1'b1;
               end
            end
            2'b01: begin
               data0_r  <= data1_r;
               tag0_r   <= tag1_r;
               valid0_r <= valid1_r;
               valid1_r <= 1'b0;
            end
            2'b11: begin
               if (valid1_r) begin
                  data0_r <= data1_r;
                  tag0_r  <= tag1_r;
                  data1_r <= push_data;
                  tag1_r  <= push_tag;
               end else begin
                  data0_r <= push_data;
                  tag0_r  <= push_tag;
               end
            end
            default: begin
               valid0_r <= valid0_r;
            end
         endcase
      end
   end

   assign occupancy  = {valid0_r & valid1_r, valid0_r ^ valid1_r};
   assign head_valid = valid0_r;
   assign head_data  = data0_r;
   assign head_tag   = tag0_r;
endmodule

// File: rtl/layer2_window_fetch.sv
// Walks every 3x3 window of the layer-1 result map, issues the nine tap reads per output
// position and streams the returned words downstream through a 2-entry skid buffer.
module layer2_window_fetch
   import cnn_pkg::*;
#(
   parameter int MAP_W  = cnn_pkg::MAP_W,
   parameter int K      = cnn_pkg::K,
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int ADDR_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    read_row_addr,
   output logic [ADDR_W-1:0]    read_col_addr,
   output logic                 layer1_result_read_signal,
   input  logic [DATA_W-1:0]    layer1_result_output,
   layer2_window_fetch_if.master win
);
   localparam int OUT_W = MAP_W - K + 1;

   win_fetch_state_t  state_r;
   logic              busy_r;
   logic              done_r;
   logic              rd_en_r;
   logic [1:0]        k_col_r;
   logic [1:0]        k_row_r;
   logic [7:0]        out_col_r;
   logic [7:0]        out_row_r;
   logic [ADDR_W-1:0] row_addr_r;
   logic [ADDR_W-1:0] col_addr_r;
   logic              inflight_r;
   win_tag_t          inflight_tag_r;

   logic [1:0]        k_col_nx_s;
   logic [1:0]        k_row_nx_s;
   logic [7:0]        out_col_nx_s;
   logic [7:0]        out_row_nx_s;
   logic              kc_wrap_s;
   logic              kr_wrap_s;
   logic              oc_wrap_s;
   logic              or_wrap_s;
   logic              pop_s;
   logic [2:0]        pending_s;
   logic              issue_s;
   logic              last_issue_s;
   logic              drain_empty_s;
   win_tag_t          issue_tag_s;

   logic [1:0]        occ_s;
   logic              head_valid_s;
   logic [DATA_W-1:0] head_data_s;
   win_tag_t          head_tag_s;

   // Issue decision: words already buffered plus the one in flight must leave room
   always_comb begin
      pop_s     = head_valid_s & win.win_ready;
      pending_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
      if ((state_r == ST_FETCH) && (pending_s < 3'd2)) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
      last_issue_s  = issue_s & kc_wrap_s & kr_wrap_s & oc_wrap_s & or_wrap_s;
      drain_empty_s = !inflight_r && ((occ_s == 2'd0) || ((occ_s == 2'd1) && pop_s));
   end

   // Next window position: k_col innermost, then k_row, out_col, out_row
   always_comb begin
      kc_wrap_s    = (k_col_r == 2'(K - 1));
      kr_wrap_s    = (k_row_r == 2'(K - 1));
      oc_wrap_s    = (out_col_r == 8'(OUT_W - 1));
      or_wrap_s    = (out_row_r == 8'(OUT_W - 1));
      k_col_nx_s   = k_col_r;
      k_row_nx_s   = k_row_r;
      out_col_nx_s = out_col_r;
      out_row_nx_s = out_row_r;
      if (!kc_wrap_s) begin
         k_col_nx_s = k_col_r + 2'd1;
      end else begin
         k_col_nx_s = 2'd0;
         if (!kr_wrap_s) begin
            k_row_nx_s = k_row_r + 2'd1;
         end else begin
            k_row_nx_s = 2'd0;
            if (!oc_wrap_s) begin
               out_col_nx_s = out_col_r + 8'd1;
            end else begin
               out_col_nx_s = 8'd0;
               if (!or_wrap_s) begin
                  out_row_nx_s = out_row_r + 8'd1;
               end else begin
                  out_row_nx_s = 8'd0;
               end
            end
         end
      end
      issue_tag_s.tap      = tap_index(k_row_r, k_col_r);
      issue_tag_s.row      = out_row_r;
      issue_tag_s.col      = out_col_r;
      issue_tag_s.last_tap = kc_wrap_s & kr_wrap_s;
      issue_tag_s.last     = kc_wrap_s & kr_wrap_s & oc_wrap_s & or_wrap_s;
   end

   // Position counters and address registers; the address on the bus is the one being issued
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_col_r        <= 2'd0;
         k_row_r        <= 2'd0;
         out_col_r      <= 8'd0;
         out_row_r      <= 8'd0;
         row_addr_r     <= '0;
         col_addr_r     <= '0;
         inflight_r     <= 1'b0;
         inflight_tag_r <= '0;
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            inflight_tag_r <= issue_tag_s;
         end
         if ((state_r == ST_IDLE) && start) begin
            k_col_r    <= 2'd0;
            k_row_r    <= 2'd0;
            out_col_r  <= 8'd0;
            out_row_r  <= 8'd0;
            row_addr_r <= '0;
            col_addr_r <= '0;
         end else if (issue_s) begin
            k_col_r    <= k_col_nx_s;
            k_row_r    <= k_row_nx_s;
            out_col_r  <= out_col_nx_s;
            out_row_r  <= out_row_nx_s;
            row_addr_r <= ADDR_W'(out_row_nx_s) + ADDR_W'(k_row_nx_s);
            col_addr_r <= ADDR_W'(out_col_nx_s) + ADDR_W'(k_col_nx_s);
         end
      end
   end

   // Scan sequencer with registered busy/done/read-enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         rd_en_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r <= ST_FETCH;
                  busy_r  <= 1'b1;
                  rd_en_r <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
                  rd_en_r <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (last_issue_s) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Leave as the final word is accepted so done lands on the next cycle
               if (drain_empty_s) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                  rd_en_r <= 1'b0;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               rd_en_r <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               rd_en_r <= 1'b0;
            end
         endcase
      end
   end

   win_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .push       (inflight_r),
      .push_data  (layer1_result_output),
      .push_tag   (inflight_tag_r),
      .pop        (pop_s),
      .occupancy  (occ_s),
      .head_valid (head_valid_s),
      .head_data  (head_data_s),
      .head_tag   (head_tag_s)
   );

   assign busy                      = busy_r;
   assign done                      = done_r;
   assign read_row_addr             = row_addr_r;
   assign read_col_addr             = col_addr_r;
   assign layer1_result_read_signal = rd_en_r;
   assign win.win_valid             = head_valid_s;
   assign win.win_data              = head_data_s;
   assign win.win_tap               = head_tag_s.tap;
   assign win.win_row               = head_tag_s.row;
   assign win.win_col               = head_tag_s.col;
   assign win.win_last_tap          = head_tag_s.last_tap;
   assign win.win_last              = head_tag_s.last;
endmodule
